// File: rtl/gx4000_pkg.sv
// gx4000_pkg: shared types and constants for the GX4000 cartridge SDRAM arbiter.
package gx4000_pkg;

    localparam int CART_ADDR_W = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        LOAD = 2'd1,
        DMA  = 2'd2,
        CPU  = 2'd3
    } arb_grant_e;

endpackage

// File: rtl/gx4000_cart_arbiter_if.sv
// gx4000_cart_arbiter_if: req/ack memory port between the cartridge arbiter
// (master) and the SDRAM controller (slave).
interface gx4000_cart_arbiter_if
    import gx4000_pkg::*;
#(
    parameter int ADDR_W = CART_ADDR_W
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_ack;
    logic [7:0]        mem_q;

    modport master (
        output mem_req, mem_we, mem_addr, mem_din,
        input  mem_ack, mem_q
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_din,
        output mem_ack, mem_q
    );
endinterface

// File: rtl/gx4000_arb_select.sv
// gx4000_arb_select: combinational priority picker used at the IDLE decision.
// Load beats everything; a starved CPU beats DMA; otherwise DMA beats CPU.
module gx4000_arb_select
    import gx4000_pkg::*;
#(
    parameter int CPU_STARVE_MAX = 4
) (
    input  logic       ld_pend,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic       plus_mode,
    input  logic [2:0] starve_cnt,
    output arb_grant_e grant
);

    // fixed priority with CPU starvation override
    always_comb begin
        grant = NONE;
        if (ld_pend)
            grant = LOAD;
        else if (cpu_req && (starve_cnt == 3'(CPU_STARVE_MAX)))
            grant = CPU;
        else if (dma_req && plus_mode)
            grant = DMA;
        else if (cpu_req)
            grant = CPU;
    end

endmodule

// File: rtl/gx4000_cart_arbiter.sv
// gx4000_cart_arbiter: shares the single cartridge SDRAM port between ROM-image
// load writes, CPU cartridge reads and ASIC DMA sound fetches, one transaction
// at a time.
// Optional build macro GX4000_ARB_TIMEOUT_EN: abort a BUSY transaction after
// TIMEOUT cycles without mem_ack, returning 8'hFF and setting err_timeout.
//
// state | meaning
// IDLE  | waiting; picks a winner among eligible requests
// BUSY  | mem_req held, waiting for mem_ack
// DONE  | one quiet cycle so the winner can drop its req
module gx4000_cart_arbiter
    import gx4000_pkg::*;
#(
    parameter int ADDR_W         = CART_ADDR_W,
    parameter int CPU_STARVE_MAX = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  plus_mode,
    input  logic                  ld_wr,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [7:0]            ld_data,
    output logic                  ld_pend,
    output logic                  ld_overrun,
    input  logic                  cpu_req,
    input  logic [ADDR_W-1:0]     cpu_addr,
    output logic                  cpu_ack,
    output logic [7:0]            cpu_q,
    input  logic                  dma_req,
    input  logic [ADDR_W-1:0]     dma_addr,
    output logic                  dma_ack,
    output logic [7:0]            dma_q,
    gx4000_cart_arbiter_if.master mem,
    output logic [1:0]            arb_state,
    output logic                  err_timeout
);

    arb_state_e        state, state_nxt;
    arb_grant_e        grant_sel, grant_q;
    logic [2:0]        starve_cnt;
    logic [ADDR_W-1:0] ld_addr_q;
    logic [7:0]        ld_data_q;
    logic              start, finish;
    logic              timeout_evt;
    logic              ld_clr;
    logic [7:0]        rd_data;

    gx4000_arb_select #(
        .CPU_STARVE_MAX (CPU_STARVE_MAX)
    ) u_select (
        .ld_pend    (ld_pend),
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .plus_mode  (plus_mode),
        .starve_cnt (starve_cnt),
        .grant      (grant_sel)
    );

    // state register
    always_ff @(posedge clk_sys) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state plus the start/finish strobes of a transaction
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_sel != NONE) begin
                    start     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem.mem_ack || timeout_evt) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem.mem_req = (state == BUSY);
    assign arb_state   = state;
    assign rd_data     = timeout_evt ? 8'hFF : mem.mem_q;
    assign ld_clr      = finish && (grant_q == LOAD);

`ifdef GX4000_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;
    logic [TO_W-1:0] to_cnt;

    // BUSY watchdog: reload while idle, count down while waiting for mem_ack
    always_ff @(posedge clk_sys) begin
        if (reset)
            to_cnt <= '0;
        else if (state == IDLE)
            to_cnt <= TO_W'(TIMEOUT - 1);
        else if ((state == BUSY) && (to_cnt != '0))
            to_cnt <= to_cnt - TO_W'(1);
    end

    assign timeout_evt = (state == BUSY) && !mem.mem_ack && (to_cnt == '0);

    // sticky abort flag
    always_ff @(posedge clk_sys) begin
        if (reset)
            err_timeout <= 1'b0;
        else if (timeout_evt)
            err_timeout <= 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_evt    = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    // load holding register; a completing load frees the slot for a same-cycle write
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ld_pend    <= 1'b0;
            ld_overrun <= 1'b0;
            ld_addr_q  <= '0;
            ld_data_q  <= '0;
        end else begin
            if (ld_wr && (!ld_pend || ld_clr)) begin
                ld_pend   <= 1'b1;
                ld_addr_q <= ld_addr;
                ld_data_q <= ld_data;
            end else if (ld_clr) begin
                ld_pend <= 1'b0;
            end
            if (ld_wr && ld_pend && !ld_clr)
                ld_overrun <= 1'b1;
        end
    end

    // consecutive DMA wins while the CPU waits
    always_ff @(posedge clk_sys) begin
        if (reset)
            starve_cnt <= '0;
        else if (!cpu_req || (start && (grant_sel == CPU)))
            starve_cnt <= '0;
        else if (start && (grant_sel == DMA) && (starve_cnt != 3'd7))
            starve_cnt <= starve_cnt + 3'd1;
    end

    // memory command latch at grant, data return and ack pulse at completion
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            grant_q      <= NONE;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_din  <= '0;
            cpu_ack      <= 1'b0;
            dma_ack      <= 1'b0;
            cpu_q        <= 8'h00;
            dma_q        <= 8'h00;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (start) begin
                grant_q <= grant_sel;
                case (grant_sel)
                    LOAD: begin
                        mem.mem_we   <= 1'b1;
                        mem.mem_addr <= ld_addr_q;
                        mem.mem_din  <= ld_data_q;
                    end
                    DMA: begin
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= dma_addr;
                        mem.mem_din  <= 8'h00;
                    end
                    CPU: begin
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= cpu_addr;
                        mem.mem_din  <= 8'h00;
                    end
                    default: ;
                endcase
            end
            if (finish) begin
                case (grant_q)
                    CPU: begin
                        cpu_ack <= 1'b1;
                        cpu_q   <= rd_data;
                    end
                    DMA: begin
                        dma_ack <= 1'b1;
                        dma_q   <= rd_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gx4000_cart_arbiter.sv
// tb_gx4000_cart_arbiter: directed and randomized checks of the cartridge arbiter
// against a simple memory responder and rule-level expectations.
module tb_gx4000_cart_arbiter;
    import gx4000_pkg::*;

    localparam int AW    = CART_ADDR_W;
    localparam int STARV = 4;

    logic          clk_sys  = 1'b0;
    logic          reset    = 1'b1;
    logic          plus_mode = 1'b0;
    logic          ld_wr    = 1'b0;
    logic [AW-1:0] ld_addr  = '0;
    logic [7:0]    ld_data  = '0;
    logic          ld_pend, ld_overrun;
    logic          cpu_req  = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_ack;
    logic [7:0]    cpu_q;
    logic          dma_req  = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic          dma_ack;
    logic [7:0]    dma_q;
    logic [1:0]    arb_state;
    logic          err_timeout;

    gx4000_cart_arbiter_if #(.ADDR_W(AW)) mem ();

    gx4000_cart_arbiter #(
        .ADDR_W         (AW),
        .CPU_STARVE_MAX (STARV),
        .TIMEOUT        (64)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .plus_mode   (plus_mode),
        .ld_wr       (ld_wr),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_pend     (ld_pend),
        .ld_overrun  (ld_overrun),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ack     (cpu_ack),
        .cpu_q       (cpu_q),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_ack     (dma_ack),
        .dma_q       (dma_q),
        .mem         (mem),
        .arb_state   (arb_state),
        .err_timeout (err_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // memory responder settings and transaction log
    int         mem_lat   = 0;
    bit         lat_rand  = 1'b0;
    bit         mem_hold  = 1'b0;
    bit         data_rand = 1'b0;
    logic [7:0] mem_data  = 8'h00;

    logic          log_we[$];
    logic [AW-1:0] log_addr[$];
    logic [7:0]    log_din[$];
    logic [7:0]    log_q[$];
    int            log_cyc[$];

    initial begin
        int  wait_cnt;
        int  cur_lat;
        bit  in_txn;
        bit  ack_done;
        wait_cnt = 0; cur_lat = 0; in_txn = 1'b0; ack_done = 1'b0;
        mem.mem_ack = 1'b0;
        mem.mem_q   = 8'h00;
        forever begin
            @(posedge clk_sys); #1;
            mem.mem_ack = 1'b0;
            if (mem.mem_req !== 1'b1) begin
                in_txn = 1'b0; ack_done = 1'b0; wait_cnt = 0;
            end else if (!ack_done) begin
                if (!in_txn) begin
                    in_txn   = 1'b1;
                    wait_cnt = 0;
                    cur_lat  = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (!mem_hold && wait_cnt == cur_lat) begin
                    mem.mem_ack = 1'b1;
                    mem.mem_q   = data_rand ? 8'($urandom) : mem_data;
                    ack_done    = 1'b1;
                    log_we.push_back(mem.mem_we);
                    log_addr.push_back(mem.mem_addr);
                    log_din.push_back(mem.mem_din);
                    log_q.push_back(mem.mem_q);
                    log_cyc.push_back(cyc);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        log_we.delete(); log_addr.delete(); log_din.delete(); log_q.delete(); log_cyc.delete();
    endtask

    // ev: 0 none, 1 load completed, 2 dma ack, 3 cpu ack
    task automatic wait_evt(input int budget, output int ev);
        logic pend_prev;
        ev = 0;
        pend_prev = ld_pend;
        for (int i = 0; i < budget && ev == 0; i++) begin
            tick();
            if (cpu_ack === 1'b1)                           ev = 3;
            else if (dma_ack === 1'b1)                      ev = 2;
            else if (pend_prev === 1'b1 && ld_pend === 1'b0) ev = 1;
            pend_prev = ld_pend;
        end
    endtask

    task automatic verify_ev(input string tag, input int ev, input int exp_ev, input logic exp_we,
                             input logic [AW-1:0] exp_addr, input logic [7:0] exp_din);
        int            c;
        logic          w;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [7:0]    q;
        check({tag, "_who"}, ev, exp_ev);
        check({tag, "_nlog"}, log_cyc.size(), 1);
        if (log_cyc.size() > 0) begin
            c = log_cyc.pop_front(); w = log_we.pop_front(); a = log_addr.pop_front();
            d = log_din.pop_front(); q = log_q.pop_front();
            check({tag, "_lat"}, cyc, c + 1);
            check({tag, "_we"}, w, exp_we);
            check({tag, "_addr"}, a, exp_addr);
            if (exp_we) check({tag, "_din"}, d, exp_din);
            if (ev == 3) check({tag, "_cpu_q"}, cpu_q, q);
            if (ev == 2) check({tag, "_dma_q"}, dma_q, q);
        end
        clear_logs();
    endtask

    initial begin
        int            ev;
        int            exp_ev;
        int            exp_q[$];
        bit            use_ld, use_cpu, use_dma, pm;
        logic [AW-1:0] la, ca, da;
        logic [7:0]    ldd;

        // reset values
        reset = 1'b1;
        tick(3);
        check("rst_mem_req", mem.mem_req, 0);
        check("rst_mem_we", mem.mem_we, 0);
        check("rst_mem_addr", mem.mem_addr, 0);
        check("rst_mem_din", mem.mem_din, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_dma_ack", dma_ack, 0);
        check("rst_cpu_q", cpu_q, 0);
        check("rst_dma_q", dma_q, 0);
        check("rst_ld_pend", ld_pend, 0);
        check("rst_ld_overrun", ld_overrun, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_state", arb_state, 0);
        reset = 1'b0;
        tick();

        // load write, k = 2
        clear_logs();
        mem_lat = 2;
        ld_wr = 1'b1; ld_addr = 25'h000100; ld_data = 8'hA5;
        tick();
        ld_wr = 1'b0;
        check("ld_pend_set", ld_pend, 1);
        check("ld_idle_n", arb_state, 0);
        tick();
        check("ld_mem_req", mem.mem_req, 1);
        check("ld_mem_we", mem.mem_we, 1);
        check("ld_mem_addr", mem.mem_addr, 25'h000100);
        check("ld_mem_din", mem.mem_din, 8'hA5);
        check("ld_busy", arb_state, 1);
        tick(2);
        check("ld_pend_n3", ld_pend, 1);
        tick();
        check("ld_pend_n4", ld_pend, 0);
        check("ld_done", arb_state, 2);
        check("ld_mem_req_done", mem.mem_req, 0);
        check("ld_no_cpu_ack", cpu_ack, 0);
        check("ld_no_dma_ack", dma_ack, 0);
        tick();
        check("ld_idle_n5", arb_state, 0);

        // CPU read, k = 0
        clear_logs();
        mem_lat = 0; mem_data = 8'h3C;
        cpu_req = 1'b1; cpu_addr = 25'h004000;
        tick();
        check("cpu_mem_req", mem.mem_req, 1);
        check("cpu_mem_we", mem.mem_we, 0);
        check("cpu_mem_addr", mem.mem_addr, 25'h004000);
        check("cpu_ack_early", cpu_ack, 0);
        tick();
        check("cpu_ack_pulse", cpu_ack, 1);
        check("cpu_q_val", cpu_q, 8'h3C);
        check("cpu_no_dma_ack", dma_ack, 0);
        check("cpu_done", arb_state, 2);
        cpu_req = 1'b0;
        tick();
        check("cpu_ack_off", cpu_ack, 0);
        check("cpu_q_hold", cpu_q, 8'h3C);
        check("cpu_idle", arb_state, 0);

        // ld_wr in the same cycle as a load completion
        clear_logs();
        ld_wr = 1'b1; ld_addr = 25'h0001A0; ld_data = 8'h11;
        tick();
        ld_wr = 1'b0;
        tick();
        check("sim_busy", arb_state, 1);
        ld_wr = 1'b1; ld_addr = 25'h0001A4; ld_data = 8'h22;
        tick();
        ld_wr = 1'b0;
        check("sim_pend_kept", ld_pend, 1);
        check("sim_no_overrun", ld_overrun, 0);
        check("sim_done", arb_state, 2);
        tick(2);
        check("sim_2nd_req", mem.mem_req, 1);
        check("sim_2nd_addr", mem.mem_addr, 25'h0001A4);
        check("sim_2nd_din", mem.mem_din, 8'h22);
        tick();
        check("sim_2nd_clear", ld_pend, 0);
        tick();

        // second ld_wr while pending is dropped
        clear_logs();
        ld_wr = 1'b1; ld_addr = 25'h0002B0; ld_data = 8'h33;
        tick();
        ld_wr = 1'b1; ld_addr = 25'h0002B4; ld_data = 8'h44;
        tick();
        ld_wr = 1'b0;
        check("ovr_set", ld_overrun, 1);
        check("ovr_addr_first", mem.mem_addr, 25'h0002B0);
        check("ovr_din_first", mem.mem_din, 8'h33);
        tick();
        check("ovr_pend_clear", ld_pend, 0);
        tick(3);
        check("ovr_no_second", arb_state, 0);
        check("ovr_no_req", mem.mem_req, 0);
        check("ovr_sticky", ld_overrun, 1);

        // reset in the middle of a load transaction
        clear_logs();
        mem_hold = 1'b1;
        ld_wr = 1'b1; ld_addr = 25'h0003C0; ld_data = 8'h55;
        tick();
        ld_wr = 1'b0;
        tick(2);
        check("rmid_busy_req", mem.mem_req, 1);
        reset = 1'b1;
        tick();
        check("rmid_req_drop", mem.mem_req, 0);
        check("rmid_state", arb_state, 0);
        check("rmid_pend_lost", ld_pend, 0);
        check("rmid_overrun_clr", ld_overrun, 0);
        reset = 1'b0;
        mem_hold = 1'b0;
        tick(3);
        check("rmid_no_replay", arb_state, 0);
        check("rmid_no_req", mem.mem_req, 0);

`ifdef GX4000_ARB_TIMEOUT_EN
        // withheld mem_ack hits the 64-cycle BUSY limit
        clear_logs();
        mem_hold = 1'b1;
        cpu_req = 1'b1; cpu_addr = 25'h000777;
        tick();
        check("to_req_n1", mem.mem_req, 1);
        tick(63);
        check("to_req_n64", mem.mem_req, 1);
        check("to_no_ack_n64", cpu_ack, 0);
        tick();
        check("to_ack", cpu_ack, 1);
        check("to_q_ff", cpu_q, 8'hFF);
        check("to_err", err_timeout, 1);
        check("to_req_drop", mem.mem_req, 0);
        cpu_req = 1'b0;
        mem_hold = 1'b0;
        tick(2);
        clear_logs();
`endif

        // CPU and DMA held, plus_mode = 1: DMA x4, CPU, repeat
        clear_logs();
        lat_rand = 1'b1; data_rand = 1'b1;
        plus_mode = 1'b1;
        cpu_addr = AW'($urandom); dma_addr = cpu_addr ^ 25'h1;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_ev = ((i % (STARV + 1)) == STARV) ? 3 : 2;
            wait_evt(20, ev);
            verify_ev($sformatf("fair%0d", i), ev, exp_ev, 1'b0, (exp_ev == 3) ? cpu_addr : dma_addr, 8'h00);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick(4);

        // same with plus_mode = 0: only CPU is served
        clear_logs();
        plus_mode = 1'b0;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_evt(20, ev);
            verify_ev($sformatf("mask%0d", i), ev, 3, 1'b0, cpu_addr, 8'h00);
        end
        cpu_req = 1'b0;
        wait_evt(8, ev);
        check("mask_no_dma", ev, 0);
        dma_req = 1'b0;
        tick(2);

        // random mixes of simultaneous requesters
        for (int r = 0; r < 25; r++) begin
            clear_logs();
            use_ld  = 1'($urandom_range(0, 1));
            use_cpu = 1'($urandom_range(0, 1));
            use_dma = 1'($urandom_range(0, 1));
            pm      = 1'($urandom_range(0, 1));
            la = AW'($urandom); ca = AW'($urandom); da = AW'($urandom); ldd = 8'($urandom);
            plus_mode = pm;
            cpu_addr = ca; dma_addr = da;
            if (use_ld) begin
                ld_wr = 1'b1; ld_addr = la; ld_data = ldd;
                tick();
                ld_wr = 1'b0;
            end
            cpu_req = use_cpu; dma_req = use_dma;
            exp_q.delete();
            if (use_ld)            exp_q.push_back(1);
            if (use_dma && pm)     exp_q.push_back(2);
            if (use_cpu)           exp_q.push_back(3);
            foreach (exp_q[j]) begin
                wait_evt(20, ev);
                case (exp_q[j])
                    1:       verify_ev($sformatf("rnd%0d_%0d", r, j), ev, 1, 1'b1, la, ldd);
                    2:       verify_ev($sformatf("rnd%0d_%0d", r, j), ev, 2, 1'b0, da, 8'h00);
                    default: verify_ev($sformatf("rnd%0d_%0d", r, j), ev, 3, 1'b0, ca, 8'h00);
                endcase
                if (ev == 3) cpu_req = 1'b0;
                if (ev == 2) dma_req = 1'b0;
            end
            if (use_dma && !pm) begin
                wait_evt(6, ev);
                check($sformatf("rnd%0d_masked", r), ev, 0);
            end
            cpu_req = 1'b0; dma_req = 1'b0;
            tick(3);
            check($sformatf("rnd%0d_idle", r), arb_state, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
